// File: rtl/risc_pkg.sv
// Shared definitions for the RISC CPU datapath blocks.
package risc_pkg;

    localparam int ADDR_W = 13;
    localparam int OPC_W  = 3;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        HLT = 3'd0,
        SKZ = 3'd1,
        ADD = 3'd2,
        AND = 3'd3,
        XOR = 3'd4,
        LDA = 3'd5,
        STO = 3'd6,
        JMP = 3'd7
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD_HI = 2'd1,
        ST_RD_LO = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: reads two program-memory bytes per instruction and latches opcode/operand.
// Memory handshake: mem_rd is held with a stable mem_addr until mem_ack=1 at a rising edge.
module instr_fetch #(
    parameter int ADDR_W = risc_pkg::ADDR_W,
    parameter int OPC_W  = risc_pkg::OPC_W,
    parameter int DATA_W = risc_pkg::DATA_W
) (
    input  logic                   clock,
    input  logic                   rst,
    input  logic                   fetch_start,
    input  logic [ADDR_W-1:0]      pc_addr,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_rd,
    input  logic [DATA_W-1:0]      mem_data,
    input  logic                   mem_ack,
    output logic                   pc_inc,
    output logic [OPC_W-1:0]       opcode,
    output logic [ADDR_W-1:0]      ir_addr,
    output logic                   ir_valid,
    output logic                   busy,
    output risc_pkg::fetch_state_t dbg_state
);

    import risc_pkg::*;

    fetch_state_t      state_q, state_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic              mem_rd_q, mem_rd_d;
    logic              busy_q, busy_d;
    logic              pc_inc_q, pc_inc_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [OPC_W-1:0]  opcode_q, opcode_d;
    logic [ADDR_W-1:0] ir_addr_q, ir_addr_d;
    logic              ir_valid_q, ir_valid_d;

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= '0;
            mem_rd_q   <= 1'b0;
            busy_q     <= 1'b0;
            pc_inc_q   <= 1'b0;
            hi_q       <= '0;
            opcode_q   <= '0;
            ir_addr_q  <= '0;
            ir_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            mem_rd_q   <= mem_rd_d;
            busy_q     <= busy_d;
            pc_inc_q   <= pc_inc_d;
            hi_q       <= hi_d;
            opcode_q   <= opcode_d;
            ir_addr_q  <= ir_addr_d;
            ir_valid_q <= ir_valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        mem_rd_d   = mem_rd_q;
        busy_d     = busy_q;
        pc_inc_d   = 1'b0;
        hi_d       = hi_q;
        opcode_d   = opcode_q;
        ir_addr_d  = ir_addr_q;
        ir_valid_d = ir_valid_q;

        unique case (state_q)
            ST_IDLE: begin
                // Old opcode/ir_addr stay visible; only ir_valid drops on a new fetch.
                if (fetch_start) begin
                    mem_addr_d = pc_addr;
                    mem_rd_d   = 1'b1;
                    busy_d     = 1'b1;
                    ir_valid_d = 1'b0;
                    state_d    = ST_RD_HI;
                end
            end
            ST_RD_HI: begin
                if (mem_ack) begin
                    hi_d       = mem_data;
                    mem_addr_d = mem_addr_q + ADDR_W'(1);
                    pc_inc_d   = 1'b1;
                    state_d    = ST_RD_LO;
                end
            end
            ST_RD_LO: begin
                if (mem_ack) begin
                    opcode_d   = hi_q[DATA_W-1 -: OPC_W];
                    ir_addr_d  = {hi_q[ADDR_W-DATA_W-1:0], mem_data};
                    ir_valid_d = 1'b1;
                    pc_inc_d   = 1'b1;
                    mem_rd_d   = 1'b0;
                    busy_d     = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign mem_addr  = mem_addr_q;
    assign mem_rd    = mem_rd_q;
    assign busy      = busy_q;
    assign pc_inc    = pc_inc_q;
    assign opcode    = opcode_q;
    assign ir_addr   = ir_addr_q;
    assign ir_valid  = ir_valid_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: memory responder, fetch driver, instruction scoreboard and report.
module tb_instr_fetch;

    import risc_pkg::*;

    localparam int MEM_SIZE = 8192;

    logic              clock;
    logic              rst;
    logic              fetch_start;
    logic [12:0]       pc_addr;
    logic [12:0]       mem_addr;
    logic              mem_rd;
    logic [7:0]        mem_data;
    logic              mem_ack;
    logic              pc_inc;
    logic [2:0]        opcode;
    logic [12:0]       ir_addr;
    logic              ir_valid;
    logic              busy;
    fetch_state_t      dbg_state;

    logic [7:0]  mem [0:MEM_SIZE-1];
    logic        resp_ack;
    logic        force_ack;
    logic        resp_en;
    logic        rand_wait;
    int          wait_cycles;
    int          wait_cnt;

    logic [15:0] exp_q[$];
    int          exp_addr_q[$];
    int          n_checks;
    int          n_fail;
    int          pc_inc_seen;
    int          exp_pc_inc;
    int          last_exp;
    logic        prev_valid;

    instr_fetch dut (
        .clock       (clock),
        .rst         (rst),
        .fetch_start (fetch_start),
        .pc_addr     (pc_addr),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .mem_data    (mem_data),
        .mem_ack     (mem_ack),
        .pc_inc      (pc_inc),
        .opcode      (opcode),
        .ir_addr     (ir_addr),
        .ir_valid    (ir_valid),
        .busy        (busy),
        .dbg_state   (dbg_state)
    );

    assign mem_data = mem[mem_addr];
    assign mem_ack  = resp_ack | force_ack;

    // ---------------- clock / watchdog ----------------
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name);
        n_fail++;
        $display("FAIL %s", name);
    endtask

    // Reference: first byte = {opcode, operand[12:8]}, second byte = operand[7:0].
    function automatic logic [15:0] model_instr(input int pc);
        int hi, lo, op, ad;
        hi = int'(mem[pc % MEM_SIZE]);
        lo = int'(mem[(pc + 1) % MEM_SIZE]);
        op = hi / 32;
        ad = (hi % 32) * 256 + lo;
        return 16'(op * 8192 + ad);
    endfunction

    // ---------------- memory responder ----------------
    always @(negedge clock) begin
        if (resp_ack) begin
            resp_ack = 1'b0;
            wait_cnt = 0;
            if (rand_wait) wait_cycles = $urandom_range(0, 3);
        end
        if (mem_rd && resp_en && !rst) begin
            if (exp_addr_q.size() == 0) begin
                report_fail("unexpected_mem_rd");
            end else begin
                check("mem_addr", 32'(mem_addr), 32'(exp_addr_q[0]));
                if (wait_cnt >= wait_cycles) begin
                    resp_ack = 1'b1;
                    void'(exp_addr_q.pop_front());
                end else begin
                    wait_cnt++;
                end
            end
        end else if (!mem_rd) begin
            wait_cnt = 0;
        end
    end

    // ---------------- output monitor / scoreboard ----------------
    always @(negedge clock) begin
        int e;
        if (pc_inc) pc_inc_seen++;
        if (ir_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                report_fail("unexpected_ir_valid");
            end else begin
                e = int'(exp_q.pop_front());
                check("sb_opcode", 32'(opcode), 32'(e / 8192));
                check("sb_ir_addr", 32'(ir_addr), 32'(e % 8192));
            end
        end
        prev_valid = ir_valid;
    end

    // ---------------- driver ----------------
    task automatic do_fetch(input int pc, input bit glitch, output int lat);
        logic [15:0] e;
        e = model_instr(pc);
        @(negedge clock);
        fetch_start = 1'b1;
        pc_addr     = 13'(pc);
        exp_q.push_back(e);
        exp_addr_q.push_back(pc % MEM_SIZE);
        exp_addr_q.push_back((pc + 1) % MEM_SIZE);
        exp_pc_inc += 2;
        @(posedge clock);
        #1;
        fetch_start = 1'b0;
        check("start_mem_rd", 32'(mem_rd), 32'd1);
        check("start_busy", 32'(busy), 32'd1);
        check("start_mem_addr", 32'(mem_addr), 32'(pc % MEM_SIZE));
        check("start_ir_valid", 32'(ir_valid), 32'd0);
        check("hold_opcode", 32'(opcode), 32'(last_exp / 8192));
        check("hold_ir_addr", 32'(ir_addr), 32'(last_exp % 8192));
        lat = 0;
        while (!ir_valid && lat < 200) begin
            @(negedge clock);
            fetch_start = glitch && (lat == 0);
            pc_addr     = 13'(pc ^ 16'h0555);
            @(posedge clock);
            #1;
            fetch_start = 1'b0;
            lat++;
        end
        if (!ir_valid) report_fail("fetch_timeout");
        check("done_busy", 32'(busy), 32'd0);
        check("done_mem_rd", 32'(mem_rd), 32'd0);
        last_exp = int'(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_rd"}, 32'(mem_rd), 32'd0);
        check({tag, "_pc_inc"}, 32'(pc_inc), 32'd0);
        check({tag, "_opcode"}, 32'(opcode), 32'd0);
        check({tag, "_ir_addr"}, 32'(ir_addr), 32'd0);
        check({tag, "_ir_valid"}, 32'(ir_valid), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_state"}, 32'(dbg_state), 32'(ST_IDLE));
    endtask

    task automatic check_pc_inc(input string name);
        @(negedge clock);
        #1;
        check(name, 32'(pc_inc_seen), 32'(exp_pc_inc));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int lat;
        int cyc;
        rst = 1'b1; fetch_start = 1'b0; pc_addr = '0; force_ack = 1'b0;
        resp_ack = 1'b0; resp_en = 1'b1; rand_wait = 1'b0; wait_cycles = 0; wait_cnt = 0;
        n_checks = 0; n_fail = 0; pc_inc_seen = 0; exp_pc_inc = 0; last_exp = 0; prev_valid = 1'b0;
        for (int i = 0; i < MEM_SIZE; i++) mem[i] = 8'($urandom_range(0, 255));

        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        rst = 1'b0;

        // Zero-wait JMP fetch, then back-to-back repeat
        mem[16] = 8'hE1; mem[17] = 8'h23;
        wait_cycles = 0;
        do_fetch(16, 1'b0, lat);
        check("t1_latency", 32'(lat), 32'd2);
        check("t1_opcode", 32'(opcode), 32'(JMP));
        check("t1_ir_addr", 32'(ir_addr), 32'h0123);
        do_fetch(16, 1'b0, lat);
        check("b2b_latency", 32'(lat), 32'd2);
        check_pc_inc("t1_pc_inc");

        // Three wait cycles before each ack
        wait_cycles = 3;
        do_fetch(16, 1'b0, lat);
        check("wait3_latency", 32'(lat), 32'd8);
        check_pc_inc("wait3_pc_inc");

        // Address wrap 0x1FFF -> 0x0000
        wait_cycles = 0;
        mem[8191] = 8'hA0; mem[0] = 8'h05;
        do_fetch(8191, 1'b0, lat);
        check("wrap_opcode", 32'(opcode), 32'(LDA));
        check("wrap_ir_addr", 32'(ir_addr), 32'h0005);
        check_pc_inc("wrap_pc_inc");

        // Ack in IDLE, then fetch_start during RD_HI: both ignored
        @(negedge clock);
        force_ack = 1'b1;
        @(posedge clock);
        #1;
        check("idle_ack_state", 32'(dbg_state), 32'(ST_IDLE));
        check("idle_ack_mem_rd", 32'(mem_rd), 32'd0);
        @(negedge clock);
        force_ack = 1'b0;
        check_pc_inc("idle_ack_pc_inc");
        wait_cycles = 3;
        do_fetch(16, 1'b1, lat);
        check("glitch_latency", 32'(lat), 32'd8);
        repeat (4) @(posedge clock);
        #1;
        check("glitch_mem_rd", 32'(mem_rd), 32'd0);
        check("glitch_exp_q", 32'(exp_q.size()), 32'd0);
        check_pc_inc("glitch_pc_inc");

        // Reset while waiting for the low byte
        wait_cycles = 2;
        @(negedge clock);
        fetch_start = 1'b1;
        pc_addr     = 13'h0200;
        exp_addr_q.push_back(32'h0200);
        exp_addr_q.push_back(32'h0201);
        exp_pc_inc += 1;
        @(posedge clock);
        #1;
        fetch_start = 1'b0;
        cyc = 0;
        while (!pc_inc && cyc < 50) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        if (!pc_inc) report_fail("rst_hi_byte_timeout");
        check("rst_pre_state", 32'(dbg_state), 32'(ST_RD_LO));
        @(negedge clock);
        rst = 1'b1;
        @(posedge clock);
        #1;
        check_all_zero("midrst");
        @(negedge clock);
        rst = 1'b0;
        exp_addr_q.delete();
        last_exp = 0;
        check_pc_inc("midrst_pc_inc");
        wait_cycles = 0;
        mem[12'h300] = 8'h40; mem[12'h301] = 8'hFF;
        do_fetch(32'h300, 1'b0, lat);
        check("post_rst_opcode", 32'(opcode), 32'(ADD));
        check("post_rst_ir_addr", 32'(ir_addr), 32'h00FF);

        // Randomized fetches with random wait states and gaps
        rand_wait = 1'b1;
        wait_cycles = $urandom_range(0, 3);
        for (int n = 0; n < 40; n++) begin
            int pc;
            pc = ($urandom_range(0, 7) == 0) ? 8191 : $urandom_range(0, MEM_SIZE - 1);
            do_fetch(pc, ($urandom_range(0, 3) == 0), lat);
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        repeat (3) @(posedge clock);
        check_pc_inc("final_pc_inc");
        check("final_exp_q", 32'(exp_q.size()), 32'd0);
        check("final_exp_addr_q", 32'(exp_addr_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the RISC CPU, directly downstream of the program counter. It takes the current `pc_addr`, reads the two instruction bytes from the 8-bit program memory over a request/acknowledge handshake, and latches the decoded instruction. The latched fields are the 3-bit opcode and the 13-bit operand address. The operand address drives the counter's `ir_addr` input for jumps, and the opcode goes to the controller.

## Interface
Parameters:
- `ADDR_W`, 13: instruction/operand address width.
- `OPC_W`, 3: opcode width.
- `DATA_W`, 8: memory data width. `OPC_W + ADDR_W` must equal `2*DATA_W`.

Ports:
- `clock`  in  1  sole clock, rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `fetch_start`  in  1  controller request to fetch the instruction at `pc_addr`.
- `pc_addr`  in  ADDR_W  address of the first instruction byte.
- `mem_addr`  out  ADDR_W  program memory byte address.
- `mem_rd`  out  1  memory read request.
- `mem_data`  in  DATA_W  read data, valid when `mem_ack`=1.
- `mem_ack`  in  1  read acknowledge; data accepted on this edge.
- `pc_inc`  out  1  one-cycle pulse per byte consumed; advances the counter.
- `opcode`  out  OPC_W  latched opcode.
- `ir_addr`  out  ADDR_W  latched operand address.
- `ir_valid`  out  1  `opcode`/`ir_addr` hold a complete instruction.
- `busy`  out  1  fetch in progress.

## Operation
- All outputs are registered. Reset value of every output is 0, and the state is IDLE.
- The FSM has three states: IDLE, RD_HI, RD_LO.
- **IDLE:** when `fetch_start`=1 at an edge:
  - load `mem_addr` from `pc_addr`;
  - set `mem_rd`=1 and `busy`=1;
  - clear `ir_valid`;
  - go to RD_HI.
- **RD_HI:** on an edge with `mem_ack`=1:
  - capture `mem_data` as the high byte;
  - set `mem_addr` to `mem_addr+1` (modulo 2^ADDR_W, so 0x1FFF wraps to 0x0000);
  - pulse `pc_inc`;
  - go to RD_LO.
- **RD_LO:** on an edge with `mem_ack`=1:
  - set `opcode` from high byte bits [7:5];
  - set `ir_addr` as {high byte [4:0], `mem_data`};
  - set `ir_valid`=1 and pulse `pc_inc`;
  - clear `mem_rd` and `busy`;
  - go to IDLE.
- `mem_rd` stays high continuously through RD_HI and RD_LO, and `mem_addr` is stable while waiting for ack.
- The fetch has no timeout: a missing `mem_ack` stalls indefinitely with `busy`=1.
- `fetch_start` while `busy`=1 is ignored and is not queued.
- `mem_ack` in IDLE is ignored.
- `ir_valid`, `opcode` and `ir_addr` hold their values until the next accepted `fetch_start`. At that point `ir_valid` drops, but `opcode`/`ir_addr` keep their old values until the new fetch completes.
- Reset mid-fetch discards the partial byte, returns to IDLE and zeroes all outputs on that edge.

## Timing
- `fetch_start` sampled at edge k gives `mem_rd`=1 and `mem_addr`=`pc_addr` after edge k.
- Minimum latency: acks at edges k+1 and k+2 give `ir_valid`=1 after edge k+2. That is 2 cycles from request to valid.
- Each wait cycle without ack adds one cycle.
- `pc_inc` is high for exactly the one cycle following each accepted ack edge: two pulses per instruction.
- Back-to-back fetches: `fetch_start` at edge k+3 is accepted, and `ir_valid` drops after k+3.
- `rst` and `fetch_start` together on one edge: reset wins.

## Structure
- Shared package `risc_pkg` holds:
  - `ADDR_W`/`OPC_W`/`DATA_W` constants;
  - opcode enum (HLT=0, SKZ, ADD, AND, XOR, LDA, STO, JMP=7);
  - the FSM state typedef.
- Single module with no sub-module. The FSM, the high-byte holding register and the address incrementer are inline.

## Test plan
- Memory[0x0010]=0xE1, [0x0011]=0x23, zero-wait ack, `fetch_start` with `pc_addr`=0x0010 -> `mem_addr` 0x0010 then 0x0011; `opcode`=7 (JMP), `ir_addr`=0x0123, `ir_valid` 2 cycles after request; two `pc_inc` pulses.
- Same fetch with 3 wait cycles before each ack -> `mem_addr`/`mem_rd` stable during waits; `ir_valid` after 8 cycles; still exactly two `pc_inc` pulses.
- `pc_addr`=0x1FFF, memory[0x1FFF]=0xA0, [0x0000]=0x05 -> second read at 0x0000; `opcode`=5 (LDA), `ir_addr`=0x0005.
- `fetch_start` pulsed during RD_HI, and `mem_ack` pulsed in IDLE -> both ignored; one instruction captured; no extra `pc_inc`.
- `rst` asserted in RD_LO after the high byte -> next cycle all outputs 0 and state IDLE. A following fetch of 0x40,0xFF yields `opcode`=2, `ir_addr`=0x00FF.
